mux16_scan_ctrl: RTL and testbench
==================================

# mux16_scan_ctrl

Sequencer that sits directly upstream of the 16:1 structural mux. It drives the mux select lines through all 16 channels, waits a programmable settle time on each enabled channel, and samples the single-bit mux output into a 16-bit snapshot word. It then hands the word downstream over a valid/ready handshake. Masked channels are skipped quickly and read back as 0.

## Interface
- SETTLE, default 2: wait cycles between driving `sel` and sampling `mux_in`; legal range 0..15.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one scan; sampled only in IDLE.
- mask  input  16  channel enables, latched when `start` is accepted; bit i=1 scans channel i.
- mux_in  input  1  output of the downstream 16:1 mux.
- sel  output  4  select driven to the 16:1 mux.
- busy  output  1  high in every state except IDLE.
- snapshot  output  16  captured word; bit i holds the value of channel i.
- valid  output  1  snapshot complete and stable.
- ready  input  1  downstream accepts the snapshot.
- scan_count  output  8  completed scans, counted on handshake; wraps 255→0.

## Operation
- Reset values, all outputs: `sel`=0, `busy`=0, `snapshot`=0, `valid`=0, `scan_count`=0; state=IDLE; internal `mask_q`, `ch` and settle counter are 0.
- `sel` is the registered channel index `ch`.
- FSM states: IDLE, SELECT, SETTLE, CAPTURE, DONE.
- IDLE:
  - If `start`=1: latch `mask_q`←`mask`, set `ch`←0, clear `snapshot`←0, go to SELECT.
  - Otherwise hold. `sel` keeps its last value.
- SELECT:
  - If `mask_q[ch]`=0: channel is skipped and its bit stays 0. If `ch`=15 go to DONE, else `ch`←`ch`+1 and stay in SELECT.
  - If `mask_q[ch]`=1: load counter←SETTLE. Go to SETTLE, or go straight to CAPTURE when SETTLE=0.
- SETTLE: decrement the counter each cycle. Stay for exactly SETTLE cycles, then go to CAPTURE.
- CAPTURE: `snapshot[ch]`←`mux_in`. If `ch`=15 go to DONE, else `ch`←`ch`+1 and go to SELECT.
- DONE:
  - `valid`=1; `snapshot` is frozen.
  - On `ready`=1: go to IDLE and increment `scan_count`.
  - If `ready` stays low, hold indefinitely.
- `sel` is constant from a channel's SELECT cycle through its CAPTURE cycle, so the mux output settles before it is sampled.
- `start` outside IDLE is ignored; there is no queueing.
- `ready` outside DONE is ignored.
- A change on `mask` after acceptance has no effect until the next scan.
- `start`=1 and `ready`=1 in the same DONE cycle: the handshake completes and `start` is ignored. A new scan needs `start` high in IDLE.
- `rst` asserted mid-scan or in DONE: the next edge forces all reset values; any partial snapshot is discarded.

## Timing
- Edge E0 is the edge that samples `start`=1 in IDLE. `busy`, `sel`=0 and the cleared `snapshot` are visible after E0.
- Cost per channel:
  - Enabled channel: SETTLE+2 cycles (SELECT, SETTLE×SETTLE, CAPTURE).
  - Masked channel: 1 cycle.
- DONE is entered, and `valid` rises, after edge E0 + Σ(channel costs).
  - All enabled, SETTLE=2: E0+64.
  - All masked: E0+16.
- `mux_in` is sampled on the edge that leaves CAPTURE for channel `ch`. It must be stable at that edge.
- Handshake:
  - `valid` falls, `busy` falls and `scan_count` increments after the edge where `valid`=`ready`=1.
  - Earliest next start: sampled on the following edge (one IDLE cycle minimum).
- `snapshot` holds its value from DONE through IDLE until the next accepted `start`.

## Test plan
- Full scan: reset, mask=16'hFFFF, SETTLE=2, model mux with in=16'hA5C3, start pulse, ready=1 → `valid` rises at E0+64, `snapshot`=16'hA5C3, `scan_count`=1; check `sel` steps 0..15, held 4 cycles each.
- Sparse mask: mask=16'h8001, in=16'hFFFF → `sel` visits 0 and 15 with settle, the others for 1 cycle each; `snapshot`=16'h8001; `valid` at E0+22.
- All masked: mask=0 → `valid` at E0+16, `snapshot`=0, `mux_in` never sampled (drive X, expect no X on `snapshot`).
- Backpressure: hold ready=0 for 20 cycles in DONE, toggling `mux_in`, `mask` and `start` → `valid`, `snapshot` and `busy` are stable; ready=1 → `valid` low next cycle; a start sampled in the same cycle is ignored.
- Reset mid-scan: assert rst at E0+30 → next edge: state IDLE, `sel`=0, `snapshot`=0, `busy`=0; a new scan completes correctly.
- SETTLE=0 variant and wrap: per enabled channel 2 cycles, `valid` at E0+32; run 256 scans → `scan_count` wraps to 0.

Source files
------------

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: steps a 16:1 mux through its channels, settles, samples each
// enabled channel into a snapshot and hands it off over valid/ready.
module mux16_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mask,
    input  logic        mux_in,
    input  logic        ready,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] snapshot,
    output logic        valid,
    output logic [7:0]  scan_count
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CAPTURE, S_DONE} state_t;
    localparam logic [3:0] SET = SETTLE[3:0];
    state_t      state;
    logic [15:0] mask_q;
    logic [3:0]  ch;
    logic [3:0]  cnt;
    assign sel = ch;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_q     <= '0;
            ch         <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            snapshot   <= '0;
            valid      <= 1'b0;
            scan_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mask_q   <= mask;
                    ch       <= '0;
                    snapshot <= '0;
                    busy     <= 1'b1;
                    state    <= S_SELECT;
                end
                S_SELECT: if (!mask_q[ch]) begin
                    if (ch == 4'd15) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                    end else begin
                        ch <= ch + 4'd1;
                    end
                end else begin
                    cnt   <= SET;
                    state <= (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
                end
                S_SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    snapshot[ch] <= mux_in;
                    if (ch == 4'd15) begin
                        state <= S_DONE;
                        valid <= 1'b1;
                    end else begin
                        ch    <= ch + 4'd1;
                        state <= S_SELECT;
                    end
                end
                S_DONE: if (ready) begin
                    valid      <= 1'b0;
                    busy       <= 1'b0;
                    scan_count <= scan_count + 8'd1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: scoreboard bench for two instances (SETTLE=2 and SETTLE=0)
// driven with directed and random scans against a channel-cost reference model.
module tb_mux16_scan_ctrl;
    typedef struct {
        int          d;
        logic [15:0] snap;
        int          lat;
        int          e0;
        logic [7:0]  cnt;
    } item_t;

    localparam int ST[2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic [15:0] mask [2];
    logic        ready [2];
    logic        mux_in [2];
    logic [15:0] pat [2];
    logic        mux_x [2];
    logic [3:0]  sel [2];
    logic        busy [2];
    logic [15:0] snapshot [2];
    logic        valid [2];
    logic [7:0]  scan_count [2];

    item_t q[$];
    item_t cur [2];
    bit    hs [2];
    bit    vprev [2];
    int    ecnt [2];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mux_in[0] = mux_x[0] ? 1'bx : pat[0][sel[0]];
    assign mux_in[1] = mux_x[1] ? 1'bx : pat[1][sel[1]];

    mux16_scan_ctrl #(.SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .mask(mask[0]), .mux_in(mux_in[0]),
        .ready(ready[0]), .sel(sel[0]), .busy(busy[0]), .snapshot(snapshot[0]),
        .valid(valid[0]), .scan_count(scan_count[0])
    );
    mux16_scan_ctrl #(.SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .mask(mask[1]), .mux_in(mux_in[1]),
        .ready(ready[1]), .sel(sel[1]), .busy(busy[1]), .snapshot(snapshot[1]),
        .valid(valid[1]), .scan_count(scan_count[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected result when valid rises, checks the count after handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (hs[d]) begin
                chk($sformatf("count%0d", d), 32'(scan_count[d]), 32'(cur[d].cnt));
                chk($sformatf("valid_fall%0d", d), 32'(valid[d]), 32'(0));
                chk($sformatf("busy_fall%0d", d), 32'(busy[d]), 32'(0));
                hs[d] = 1'b0;
            end
            if (valid[d] && !vprev[d]) begin
                if (q.size() == 0 || q[0].d != d) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid%0d: got valid with no scan pending at cycle %0d", d, cyc);
                end else begin
                    cur[d] = q.pop_front();
                    chk($sformatf("snapshot%0d", d), 32'(snapshot[d]), 32'(cur[d].snap));
                    chk($sformatf("latency%0d", d), 32'(cyc - cur[d].e0), 32'(cur[d].lat));
                end
            end
            if (valid[d] && ready[d]) hs[d] = 1'b1;
            vprev[d] = valid[d];
        end
    end

    task automatic scan(input int d, input logic [15:0] m, input logic [15:0] p, input bit bp, input bit xin);
        int k;
        int lat;
        logic [3:0] es[$];
        @(posedge clk); #1;
        k = 0;
        while (busy[d] && k < 500) begin @(posedge clk); #1; k++; end
        if (busy[d]) chk("idle_timeout", 32'(busy[d]), 32'(0));
        pat[d] = p;
        mux_x[d] = xin;
        mask[d] = m;
        start[d] = 1'b1;
        for (int c = 0; c < 16; c++) repeat (m[c] ? ST[d] + 2 : 1) es.push_back(4'(c));
        lat = es.size();
        ecnt[d] = (ecnt[d] + 1) % 256;
        q.push_back('{d, m & p, lat, cyc + 1, 8'(ecnt[d])});
        @(posedge clk); #1;
        start[d] = 1'b0;
        mask[d] = 16'($urandom);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk($sformatf("sel%0d[%0d]", d, i), 32'(sel[d]), 32'(es[i]));
        end
        k = 0;
        @(negedge clk);
        while (!valid[d] && k < 100) begin @(negedge clk); k++; end
        if (!valid[d]) chk("valid_timeout", 32'(valid[d]), 32'(1));
        if (bp) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                pat[d] = 16'($urandom);
                mask[d] = 16'($urandom);
                start[d] = 1'($urandom);
                @(negedge clk);
                chk("bp_valid", 32'(valid[d]), 32'(1));
                chk("bp_snapshot", 32'(snapshot[d]), 32'(m & p));
                chk("bp_busy", 32'(busy[d]), 32'(1));
            end
        end
        @(posedge clk); #1;
        ready[d] = 1'b1;
        start[d] = bp;
        @(posedge clk); #1;
        ready[d] = 1'b0;
        start[d] = 1'b0;
        if (bp) begin
            @(negedge clk);
            chk("start_ignored", 32'(busy[d]), 32'(0));
            @(negedge clk);
            chk("still_idle", 32'(busy[d]), 32'(0));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_sel"}, 32'(sel[d]), 32'(0));
            chk({tag, "_busy"}, 32'(busy[d]), 32'(0));
            chk({tag, "_snapshot"}, 32'(snapshot[d]), 32'(0));
            chk({tag, "_valid"}, 32'(valid[d]), 32'(0));
            chk({tag, "_count"}, 32'(scan_count[d]), 32'(0));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        ecnt[0] = 0;
        ecnt[1] = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            ready[d] = 1'b0;
            mask[d] = '0;
            pat[d] = '0;
            mux_x[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        scan(0, 16'hFFFF, 16'hA5C3, 1'b0, 1'b0);
        scan(0, 16'h8001, 16'hFFFF, 1'b0, 1'b0);
        scan(0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        scan(0, 16'($urandom), 16'($urandom), 1'b1, 1'b0);

        @(posedge clk); #1;
        mux_x[0] = 1'b0;
        pat[0] = 16'($urandom) | 16'h0001;
        mask[0] = 16'hFFFF;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ecnt[0] = 0;
        ecnt[1] = 0;
        @(negedge clk);
        check_reset_state("midscan_rst");

        scan(0, 16'hFFFF, 16'($urandom), 1'b0, 1'b0);
        repeat (5) scan(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);

        scan(1, 16'hFFFF, 16'($urandom), 1'b0, 1'b0);
        scan(1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        pulse_reset();
        repeat (256) scan(1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_count", 32'(scan_count[1]), 32'(0));

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
